seq_detector_param: RTL

Parametrised serial bit-pattern detector. It is the general successor to the fixed "three consecutive 1s" Moore detector.
- Run-time configurable pattern (1..PAT_W bits).
- Overlapping or non-overlapping match mode.
- Selectable Mealy or Moore output timing.
- Saturating match counter.
- Sits on a qualified serial bit stream (valid/a), in front of event-capture or interrupt logic.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_det_history.sv | 58 +++++
 rtl/seq_detector_param.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Widest pattern / length field any instance may use; the config container is sized for it
  localparam int unsigned PAT_MAX_W = 32;
  localparam int unsigned LEN_MAX_W = 6;

  // Width needed to hold a pattern length of 0..pat_w
  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Latched run-time configuration
  typedef struct packed {
    logic [PAT_MAX_W-1:0] pattern;
    logic [LEN_MAX_W-1:0] len;
    logic                 overlap;
    logic                 mealy;
  } seq_cfg_t;

endpackage

// File: rtl/seq_det_history.sv
// History shift register, fill counter and length-masked pattern compare.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : drop history and fill (config reload)
//   shift_en     : accept sample a this cycle
//   a            : serial data bit
//   overlap      : keep history after a hit
//   len, pattern : active pattern length and pattern (bit [len-1] oldest)
//   hit_next     : this cycle's accepted sample completes the pattern
module seq_det_history #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             a,
  input  logic             overlap,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit_next
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_inc;

  // Newest bit enters at bit 0
  assign hist_next = {hist[PAT_W-2:0], a};

  // Fill saturates at the pattern length
  assign fill_inc = (fill >= len) ? len : fill + LEN_W'(1);

  // Only the low len bits take part in the compare
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hit_next = shift_en && (fill_inc == len) &&
                    (((hist_next ^ pattern) & mask) == '0);

  // Non-overlapping mode restarts the fill after a hit so len fresh bits are needed
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      fill <= (hit_next && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with run-time pattern, overlap
// and Mealy/Moore output selection, plus a saturating match counter.
//   clk, reset   : clock, synchronous active-high reset
//   cfg_load     : strobe latching cfg_* and clearing history/counter
//   cfg_pattern  : pattern, bit [cfg_len-1] received first
//   cfg_len      : pattern length, legal 1..PAT_W
//   cfg_overlap  : allow overlapping matches
//   cfg_mealy    : 1 = Mealy output timing, 0 = Moore
//   valid, a     : qualified serial bit stream
//   match        : detection output (combinational in Mealy mode)
//   match_count  : saturating hit count since last clear
//   cfg_err      : last cfg_load had an illegal length
//   active       : detector is running
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cfg_mealy,
  input  logic             valid,
  input  logic             a,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err,
  output logic             active
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Parameter sanity
  if (PAT_W < 2 || PAT_W > PAT_MAX_W || LEN_W > LEN_MAX_W) begin : g_bad_param
    $error("seq_detector_param: unsupported PAT_W");
  end

  state_e   state;
  state_e   state_next;
  seq_cfg_t cfg_q;
  logic     cfg_legal_c;
  logic     shift_en;
  logic     hit_next;
  logic     moore_flag;
  logic     unused_cfg;

  assign cfg_legal_c = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  // cfg_load wins over a coincident sample
  assign shift_en = (state == RUN) && valid && !cfg_load;

  // Upper container bits stay zero for narrow instances
  assign unused_cfg = ^cfg_q;

  seq_det_history #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .clear    (cfg_load),
    .shift_en (shift_en),
    .a        (a),
    .overlap  (cfg_q.overlap),
    .len      (cfg_q.len[LEN_W-1:0]),
    .pattern  (cfg_q.pattern[PAT_W-1:0]),
    .hit_next (hit_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only cfg_load moves the FSM
  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = cfg_legal_c ? RUN : ERR;
    end
  end

  // Output decode: match only while running, timing per latched mode
  always_comb begin
    match = 1'b0;
    if (state == RUN) begin
      match = cfg_q.mealy ? hit_next : moore_flag;
    end
  end

  // Config latch, Moore flag, counter and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q       <= '0;
      moore_flag  <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
      active      <= 1'b0;
    end else begin
      active <= (state_next == RUN);
      if (cfg_load) begin
        cfg_q.pattern <= PAT_MAX_W'(cfg_pattern);
        cfg_q.len     <= LEN_MAX_W'(cfg_len);
        cfg_q.overlap <= cfg_overlap;
        cfg_q.mealy   <= cfg_mealy;
        moore_flag    <= 1'b0;
        match_count   <= '0;
        cfg_err       <= !cfg_legal_c;
      end else if (shift_en) begin
        moore_flag <= hit_next;
        if (hit_next && (match_count != CNT_MAX)) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
